// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: synchronises sck/cs_n/mosi into clk_sys, shifts frames MSB first
// and exchanges them with a one-entry tx buffer and a registered rx_data word.
`timescale 1ns/1ps
module spi_slave_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun
);

  // state  | meaning
  // IDLE   | not selected, miso released, sck ignored
  // ACTIVE | selected, shifting frames on synchronised sck edges
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q, vld_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_q  <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
      vld_q  <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

  logic              state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rxsh_q, rxsh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              full_q, full_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;
  logic              peek_full_q, peek_full_d;
  logic              armed_q, armed_d;
  logic              sck_rise, sck_fall, cs_fall, cs_rise;

  // cs_n only counts as falling once a genuine high has been seen after reset
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = armed_q & ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rxsh_d      = rxsh_q;
    rx_data_d   = rx_data_q;
    buf_d       = buf_q;
    full_d      = full_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    done_d      = done_q;
    pend_d      = pend_q;
    peek_full_d = peek_full_q;
    armed_d     = armed_q | (vld_q[1] & cs_q[1]);

    if (tx_valid && !full_q) begin
      buf_d  = tx_data;
      full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          done_d  = 1'b0;
          pend_d  = 1'b0;
          if (full_q) begin
            shift_d = buf_q;
            full_d  = 1'b0;
          end else begin
            shift_d    = '0;
            underrun_d = 1'b1;
          end
        end
      end
      default: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          shift_d = '0;
          rxsh_d  = '0;
          done_d  = 1'b0;
          pend_d  = 1'b0;
        end else if (sck_rise) begin
          rxsh_d = {rxsh_q[DATA_W-2:0], mosi_q[1]};
          // back-to-back load is committed only once the master really clocks the new frame
          if (pend_q) begin
            pend_d = 1'b0;
            if (peek_full_q) full_d = 1'b0;
            else             underrun_d = 1'b1;
          end
          if (cnt_q == LAST_BIT) begin
            cnt_d      = '0;
            rx_data_d  = rxsh_d;
            rx_valid_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (done_q) begin
            done_d      = 1'b0;
            pend_d      = 1'b1;
            peek_full_d = full_q;
            shift_d     = full_q ? buf_q : '0;
          end else begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rxsh_q      <= '0;
      rx_data_q   <= '0;
      buf_q       <= '0;
      full_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      peek_full_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rxsh_q      <= rxsh_d;
      rx_data_q   <= rx_data_d;
      buf_q       <= buf_d;
      full_q      <= full_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      peek_full_q <= peek_full_d;
      armed_q     <= armed_d;
    end
  end

  assign miso_oe  = (state_q == ST_ACTIVE);
  assign miso     = (state_q == ST_ACTIVE) & shift_q[DATA_W-1];
  assign tx_ready = ~full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: acts as an SPI mode-0 master at clk/10 and compares every
// frame against a byte-level model of the one-entry tx buffer.
`timescale 1ns/1ps
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       nrst, sck, cs_n, mosi;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, underrun;
  logic [7:0] tx_data, rx_data;

  spi_slave_rx #(.DATA_W(8)) dut (
    .clk(clk), .nrst(nrst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun)
  );

  always #50 clk = ~clk;

  int n_chk = 0, n_pass = 0, un_cnt = 0, m_under = 0;
  logic [7:0] rxq[$];
  realtime rxv_t = 0.0, last_rise = 0.0;
  bit m_full = 0;
  logic [7:0] m_buf = '0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxq.push_back(rx_data);
      rxv_t = $realtime;
    end
    if (underrun === 1'b1) un_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a frame the master actually clocks takes the buffered byte, or zeros plus one underrun
  function automatic logic [7:0] model_start();
    if (m_full) begin
      m_full = 0;
      return m_buf;
    end
    m_under++;
    return 8'h00;
  endfunction

  task automatic write_tx(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("tx_accept", (n < 64), 1);
    @(negedge clk);
    tx_valid = 1'b0;
    m_full = 1;
    m_buf  = d;
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, input bit wr,
                      input logic [7:0] wd, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      if (wr && i == 3) write_tx(wd);
      #500;
      sck = 1'b1;
      last_rise = $realtime;
      mi[7-i] = miso;
      #500;
      sck = 1'b0;
    end
  endtask

  task automatic cs_high();
    #500;
    cs_n = 1'b1;
    #800;
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp);
    chk({tag, "_cnt"}, rxq.size(), 1);
    if (rxq.size() > 0) chk(tag, rxq.pop_front(), exp);
    rxq.delete();
  endtask

  initial begin
    logic [7:0] mi, mi2, e, e2, r, r2, w, hold;
    int nf;
    bit wr;

    nrst = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (4) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // single frame with a buffered byte
    write_tx(8'hA5);
    cs_n = 1'b0;
    e = model_start();
    xfer(8'h3C, 8, 0, 8'h00, mi);
    chk("oe_active", miso_oe, 1);
    chk("miso_a5", mi, e);
    chk("rx_latency", ((rxv_t - last_rise) <= 450.0), 1);
    check_rx("rx_3c", 8'h3C);
    chk("rx_data_hold", rx_data, 8'h3C);
    cs_high();
    chk("oe_idle", miso_oe, 0);
    chk("miso_idle", miso, 0);
    chk("tx_ready_after", tx_ready, 1);
    chk("under_none", un_cnt, m_under);

    // back-to-back frames, second byte written mid-frame
    write_tx(8'h81);
    cs_n = 1'b0;
    e = model_start();
    xfer(8'h12, 8, 1, 8'h7E, mi);
    check_rx("rx_12", 8'h12);
    e2 = model_start();
    xfer(8'h34, 8, 0, 8'h00, mi2);
    check_rx("rx_34", 8'h34);
    cs_high();
    chk("miso_81", mi, e);
    chk("miso_7e", mi2, e2);
    chk("under_b2b", un_cnt, m_under);

    // underrun: no byte buffered
    r = 8'($urandom);
    cs_n = 1'b0;
    e = model_start();
    xfer(r, 8, 0, 8'h00, mi);
    cs_high();
    chk("miso_zero", mi, e);
    check_rx("rx_under", r);
    chk("under_one", un_cnt, m_under);

    // abort after 5 bits, then a full 0xF0 frame
    cs_n = 1'b0;
    e = model_start();
    xfer(8'($urandom), 5, 0, 8'h00, mi);
    cs_high();
    chk("abort_no_rx", rxq.size(), 0);
    chk("abort_rx_data", rx_data, r);
    w = 8'($urandom);
    write_tx(w);
    cs_n = 1'b0;
    e = model_start();
    xfer(8'hF0, 8, 0, 8'h00, mi);
    cs_high();
    chk("miso_after_abort", mi, e);
    check_rx("rx_f0", 8'hF0);
    chk("under_abort", un_cnt, m_under);

    // reset mid-frame, released with cs_n low
    write_tx(8'($urandom));
    cs_n = 1'b0;
    e = model_start();
    xfer(8'($urandom), 3, 0, 8'h00, mi);
    #200;
    nrst = 1'b0;
    #1;
    chk("mid_rst_oe", miso_oe, 0);
    chk("mid_rst_miso", miso, 0);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_rx_valid", rx_valid, 0);
    m_full = 0;
    #300;
    nrst = 1'b1;
    xfer(8'($urandom), 8, 0, 8'h00, mi);
    chk("no_start_oe", miso_oe, 0);
    chk("no_start_rx", rxq.size(), 0);
    cs_high();
    cs_n = 1'b0;
    e = model_start();
    xfer(8'h55, 8, 0, 8'h00, mi);
    cs_high();
    chk("miso_post_rst", mi, e);
    check_rx("rx_55", 8'h55);
    chk("under_post_rst", un_cnt, m_under);

    // tx_valid held against a full buffer
    write_tx(8'h11);
    @(negedge clk);
    tx_data = 8'h22;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("full_not_ready", tx_ready, 0);
    cs_n = 1'b0;
    e = model_start();
    repeat (8) @(negedge clk);
    tx_valid = 1'b0;
    chk("refill_not_ready", tx_ready, 0);
    m_full = 1;
    m_buf = 8'h22;
    r = 8'($urandom);
    r2 = 8'($urandom);
    xfer(r, 8, 0, 8'h00, mi);
    check_rx("rx_hold_a", r);
    e2 = model_start();
    xfer(r2, 8, 0, 8'h00, mi2);
    check_rx("rx_hold_b", r2);
    cs_high();
    chk("miso_11", mi, e);
    chk("miso_22", mi2, e2);
    chk("under_hold", un_cnt, m_under);

    // randomised bursts
    for (int it = 0; it < 8; it++) begin
      if (!m_full && $urandom_range(1) == 1) write_tx(8'($urandom));
      cs_n = 1'b0;
      nf = $urandom_range(3, 1);
      for (int f = 0; f < nf; f++) begin
        e = model_start();
        wr = !m_full && ($urandom_range(1) == 1);
        r = 8'($urandom);
        hold = 8'($urandom);
        xfer(r, 8, wr, hold, mi);
        chk("rnd_miso", mi, e);
        check_rx("rnd_rx", r);
      end
      cs_high();
      chk("rnd_under", un_cnt, m_under);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
